// File: rtl/sev_seg_pkg.sv
// Shared constants, types and helper functions for the three-digit
// multiplexed seven-segment display driver.
package sev_seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef enum logic [1:0] {
    DIG_UNITS,
    DIG_TENS,
    DIG_HUNDREDS
  } digit_e;

  // Active-low one-hot digit enables.
  localparam logic [2:0] EN_OFF      = 3'b111;
  localparam logic [2:0] EN_UNITS    = 3'b110;
  localparam logic [2:0] EN_TENS     = 3'b101;
  localparam logic [2:0] EN_HUNDREDS = 3'b011;

  typedef struct packed {
    logic       over;
    logic [3:0] hun;
    logic [3:0] ten;
    logic [3:0] uni;
  } bcd_t;

  // Active-low a..g on bits 0..6, dp (bit 7) always off.
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [2:0] en_pattern(input digit_e dig);
    case (dig)
      DIG_UNITS:    return EN_UNITS;
      DIG_TENS:     return EN_TENS;
      DIG_HUNDREDS: return EN_HUNDREDS;
      default:      return EN_OFF;
    endcase
  endfunction

  function automatic digit_e next_digit(input digit_e dig);
    case (dig)
      DIG_UNITS: return DIG_TENS;
      DIG_TENS:  return DIG_HUNDREDS;
      default:   return DIG_UNITS;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd10.sv
// Combinational double-dabble: 10-bit binary to three BCD digits, with a
// flag for values above 999 (whose hundreds digit would not fit).
module bin2bcd10 (
  input  logic [9:0] bin_i,
  output logic [3:0] hun_o,
  output logic [3:0] ten_o,
  output logic [3:0] uni_o,
  output logic       over_o
);

  logic [21:0] sr;

  always_comb begin
    sr = {12'd0, bin_i};
    for (int i = 0; i < 10; i++) begin
      if (sr[13:10] >= 4'd5) sr[13:10] = sr[13:10] + 4'd3;
      if (sr[17:14] >= 4'd5) sr[17:14] = sr[17:14] + 4'd3;
      if (sr[21:18] >= 4'd5) sr[21:18] = sr[21:18] + 4'd3;
      sr = {sr[20:0], 1'b0};
    end
    uni_o  = sr[13:10];
    ten_o  = sr[17:14];
    hun_o  = sr[21:18];
    over_o = (bin_i > 10'd999);
  end

endmodule

// File: rtl/sev_seg_display.sv
// Three-digit multiplexed display driver: registers the BCD of the input,
// scans units/tens/hundreds every SCAN_DIV cycles, registered en/ss outputs.
module sev_seg_display
  import sev_seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] distance,
  output logic [2:0] en,
  output logic [7:0] ss
);

  localparam logic [23:0] DIV_LAST = 24'(SCAN_DIV - 1);

  logic [23:0] cnt_q, cnt_d;
  digit_e      dig_q, dig_d;
  bcd_t        bcd_q, bcd_d;
  logic [2:0]  en_q, en_d;
  logic [7:0]  ss_q, ss_d;
  logic        wrap;
  logic [3:0]  hun, ten, uni;
  logic        over;

  bin2bcd10 u_bin2bcd (
    .bin_i  (distance),
    .hun_o  (hun),
    .ten_o  (ten),
    .uni_o  (uni),
    .over_o (over)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wrap  = (cnt_q == DIV_LAST);
    cnt_d = wrap ? 24'd0 : cnt_q + 24'd1;
    dig_d = wrap ? next_digit(dig_q) : dig_q;
    bcd_d = '{over: over, hun: hun, ten: ten, uni: uni};
    en_d  = en_pattern(dig_q);
    ss_d  = SEG_BLANK;
    // Leading zeros blank; the units digit always shows.
    case (dig_q)
      DIG_UNITS:    ss_d = seg_code(bcd_q.uni);
      DIG_TENS:     if (bcd_q.hun != 4'd0 || bcd_q.ten != 4'd0) ss_d = seg_code(bcd_q.ten);
      DIG_HUNDREDS: if (bcd_q.hun != 4'd0) ss_d = seg_code(bcd_q.hun);
      default:      ss_d = SEG_BLANK;
    endcase
    if (bcd_q.over) ss_d = SEG_DASH;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 24'd0;
      dig_q <= DIG_UNITS;
      bcd_q <= '0;
      en_q  <= EN_OFF;
      ss_q  <= SEG_BLANK;
    end else begin
      cnt_q <= cnt_d;
      dig_q <= dig_d;
      bcd_q <= bcd_d;
      en_q  <= en_d;
      ss_q  <= ss_d;
    end
  end

  assign en = en_q;
  assign ss = ss_q;

endmodule

// File: tb/tb_sev_seg_display.sv
// Scoreboard bench for sev_seg_display with SCAN_DIV = 4: stimulus queues
// per-cycle expectations, a negedge monitor compares them against en/ss.
module tb_sev_seg_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] distance;
  logic [2:0] en;
  logic [7:0] ss;

  int compared   = 0;
  int mismatched = 0;
  int cyc = 0;  // rising edges since the most recent reset release

  typedef struct {
    int         cyc;
    logic [2:0] en;
    logic [7:0] ss;
    string      name;
  } exp_t;

  typedef struct {
    logic [9:0] d;
    logic [7:0] su;
    logic [7:0] st;
    logic [7:0] sh;
    string      name;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];

  sev_seg_display #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .distance (distance),
    .en       (en),
    .ss       (ss)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Dwell of 4: cycles 1-4 units, 5-8 tens, 9-12 hundreds, then repeat.
  function automatic int dig_idx(input int k);
    return ((k - 1) / 4) % 3;
  endfunction

  function automatic logic [2:0] exp_en(input int k);
    case (dig_idx(k))
      0:       return 3'b110;
      1:       return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

  task automatic push(input int k, input logic [2:0] e, input logic [7:0] s, input string nm);
    exp_t x;
    x.cyc = k; x.en = e; x.ss = s; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic push_digit(input int k, input logic [7:0] su, input logic [7:0] st,
                            input logic [7:0] sh, input string nm);
    logic [7:0] s;
    case (dig_idx(k))
      0:       s = su;
      1:       s = st;
      default: s = sh;
    endcase
    push(k, exp_en(k), s, nm);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive a value just after edge c; it reaches ss from edge c+2 onward.
  task automatic run_value(input vec_t v);
    int c;
    c = cyc;
    distance = v.d;
    for (int k = c + 2; k <= c + 13; k++) push_digit(k, v.su, v.st, v.sh, v.name);
    repeat (13) next_cycle();
  endtask

  always @(negedge clk) begin
    if (rst_n && cyc >= 1) begin
      compared++;
      if ($countones(~en) != 1) begin
        mismatched++;
        $display("FAIL onehot cyc=%0d en=%b (need exactly one low bit)", cyc, en);
      end
    end
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      exp_t x;
      x = sb.pop_front();
      compared++;
      mismatched++;
      $display("FAIL %s cyc=%0d not sampled (needed en=%b ss=%h)", x.name, x.cyc, x.en, x.ss);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t x;
      x = sb.pop_front();
      compared++;
      if (en !== x.en || ss !== x.ss) begin
        mismatched++;
        $display("FAIL %s cyc=%0d got en=%b ss=%h need en=%b ss=%h",
                 x.name, x.cyc, en, ss, x.en, x.ss);
      end
    end
  end

  initial begin
    vecs[0] = '{10'd7,    8'hF8, 8'hFF, 8'hFF, "blank_7"};
    vecs[1] = '{10'd40,   8'hC0, 8'h99, 8'hFF, "blank_40"};
    vecs[2] = '{10'd0,    8'hC0, 8'hFF, 8'hFF, "blank_0"};
    vecs[3] = '{10'd305,  8'h92, 8'hC0, 8'hB0, "inner_zero_305"};
    vecs[4] = '{10'd999,  8'h90, 8'h90, 8'h90, "max_999"};
    vecs[5] = '{10'd1000, 8'hBF, 8'hBF, 8'hBF, "over_1000"};
    vecs[6] = '{10'd1023, 8'hBF, 8'hBF, 8'hBF, "over_1023"};
    vecs[7] = '{10'd500,  8'hC0, 8'hC0, 8'h92, "back_500"};
    vecs[8] = '{10'd123,  8'hB0, 8'hA4, 8'hF9, "scan_123_again"};

    // Power-on reset with 123 applied.
    rst_n    = 1'b0;
    distance = 10'd123;
    repeat (3) begin
      push(0, 3'b111, 8'hFF, "reset_hold");
      @(negedge clk);
      #1;
    end
    rst_n = 1'b1;
    push(1, 3'b110, 8'hC0, "reset_release");
    for (int k = 2; k <= 15; k++) push_digit(k, 8'hB0, 8'hA4, 8'hF9, "scan_123");
    repeat (15) next_cycle();

    foreach (vecs[i]) run_value(vecs[i]);

    // Latency: step 11 -> 19 while units is enabled for the next two edges.
    distance = 10'd11;
    repeat (3) next_cycle();
    for (int n = 0; n < 12 && ((cyc - 1) % 12) != 0; n++) next_cycle();
    push(cyc, 3'b110, 8'hF9, "lat_before");
    distance = 10'd19;
    push(cyc + 1, 3'b110, 8'hF9, "lat_edge1");
    push(cyc + 2, 3'b110, 8'h90, "lat_edge2");
    push(cyc + 3, 3'b110, 8'h90, "lat_edge3");
    repeat (4) next_cycle();

    // Mid-scan reset during the tens dwell.
    distance = 10'd123;
    repeat (2) next_cycle();
    for (int n = 0; n < 12 && !(dig_idx(cyc) == 1 && ((cyc - 1) % 4) == 1); n++) next_cycle();
    push(cyc, 3'b101, 8'hA4, "pre_reset_tens");
    @(negedge clk);
    next_cycle();
    rst_n = 1'b0;
    #1;
    push(0, 3'b111, 8'hFF, "midscan_reset_async");
    @(negedge clk);
    #1;
    push(0, 3'b111, 8'hFF, "midscan_reset_hold");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    push(1, 3'b110, 8'hC0, "restart_units");
    for (int k = 2; k <= 8; k++) push_digit(k, 8'hB0, 8'hA4, 8'hF9, "restart_dwell");
    repeat (9) next_cycle();

    foreach (sb[i]) begin
      compared++;
      mismatched++;
      $display("FAIL %s cyc=%0d never reached (needed en=%b ss=%h)",
               sb[i].name, sb[i].cyc, sb[i].en, sb[i].ss);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
